// File: rtl/arb_pkg.sv
// Shared types and widths for the two-source data arbiter.
// The optional beat counters are built only when ARB_CNT_EN is defined.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int ARB_DW = 32;
    localparam int BCNT_W = 4;
    localparam int CNT_W  = 16;

    // Beat counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/arb_out_reg.sv
// Single-entry output register: loads a granted beat, drains on consumer ready.
module arb_out_reg
#(
    parameter int DW = 32
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_src,
    input  logic          ld_last,
    input  logic          drain,
    output logic          vld,
    output logic [DW-1:0] data,
    output logic          src,
    output logic          last
);

    // A load in the same cycle as a drain wins, giving one beat per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
            src  <= 1'b0;
            last <= 1'b0;
        end else if (ld) begin
            vld  <= 1'b1;
            data <= ld_data;
            src  <= ld_src;
            last <= ld_last;
        end else if (drain) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/data_arbiter.sv
// Round-robin arbiter for two valid/ready sources with bounded bursts.
// Define ARB_CNT_EN to add per-source saturating beat counters and CNT_CLR.
module data_arbiter
    import arb_pkg::*;
#(
    parameter int DW        = ARB_DW,
    parameter int BURST_MAX = 4
)
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ0_VALID,
    input  logic [DW-1:0] REQ0_DATA,
    input  logic          REQ0_LAST,
    output logic          REQ0_READY,
    input  logic          REQ1_VALID,
    input  logic [DW-1:0] REQ1_DATA,
    input  logic          REQ1_LAST,
    output logic          REQ1_READY,
    output logic          OUT_VALID,
    output logic [DW-1:0] OUT_DATA,
    output logic          OUT_SRC,
    output logic          OUT_LAST,
    input  logic          OUT_READY
`ifdef ARB_CNT_EN
    ,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] GNT_CNT0,
    output logic [CNT_W-1:0] GNT_CNT1
`endif
);

    arb_state_e           state;
    logic                 last_gnt;
    logic [BCNT_W-1:0]    bcnt;

    logic [1:0]           req_vld;
    logic [1:0]           req_last;
    logic [1:0][DW-1:0]   req_data;
    logic [1:0]           rdy;
    logic [1:0]           acc;
    logic                 out_free;
    logic                 sel;
    logic                 ld;
    logic                 burst_end;

    assign req_vld  = {REQ1_VALID, REQ0_VALID};
    assign req_last = {REQ1_LAST,  REQ0_LAST};
    assign req_data = {REQ1_DATA,  REQ0_DATA};

    // The output slot is free when empty or being drained this cycle.
    assign out_free  = !OUT_VALID || OUT_READY;
    assign rdy[0]    = (state == GNT0) && out_free;
    assign rdy[1]    = (state == GNT1) && out_free;
    assign acc       = req_vld & rdy;
    assign sel       = (state == GNT1);
    assign ld        = |acc;
    assign burst_end = ld && (req_last[sel] || (bcnt == BCNT_W'(BURST_MAX - 1)));

    assign REQ0_READY = rdy[0];
    assign REQ1_READY = rdy[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            bcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    case (req_vld)
                        2'b01:   state <= GNT0;
                        2'b10:   state <= GNT1;
                        2'b11:   state <= last_gnt ? GNT0 : GNT1;
                        default: state <= IDLE;
                    endcase
                end
                GNT0, GNT1: begin
                    // A dropped VALID holds the grant; only LAST or the burst cap end it.
                    if (burst_end) begin
                        state    <= IDLE;
                        last_gnt <= sel;
                        bcnt     <= '0;
                    end else if (ld) begin
                        bcnt     <= bcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    arb_out_reg #(.DW(DW)) u_out (
        .clk     (CLK),
        .rst_n   (RST_N),
        .ld      (ld),
        .ld_data (req_data[sel]),
        .ld_src  (sel),
        .ld_last (req_last[sel]),
        .drain   (OUT_READY),
        .vld     (OUT_VALID),
        .data    (OUT_DATA),
        .src     (OUT_SRC),
        .last    (OUT_LAST)
    );

`ifdef ARB_CNT_EN
    logic [1:0][CNT_W-1:0] gnt_cnt;

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gnt_cnt <= '0;
        end else if (CNT_CLR) begin
            gnt_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) gnt_cnt[i] <= sat_inc(gnt_cnt[i]);
            end
        end
    end

    assign GNT_CNT0 = gnt_cnt[0];
    assign GNT_CNT1 = gnt_cnt[1];
`endif

endmodule

// File: tb/tb_data_arbiter.sv
// Self-checking bench for data_arbiter: directed scenarios plus a randomized
// scoreboard run; counter checks are compiled in with ARB_CNT_EN.
module tb_data_arbiter;

    localparam int DW = 32;
    localparam int BM = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          REQ0_VALID, REQ0_LAST, REQ0_READY;
    logic [DW-1:0] REQ0_DATA;
    logic          REQ1_VALID, REQ1_LAST, REQ1_READY;
    logic [DW-1:0] REQ1_DATA;
    logic          OUT_VALID, OUT_SRC, OUT_LAST, OUT_READY;
    logic [DW-1:0] OUT_DATA;
`ifdef ARB_CNT_EN
    logic          CNT_CLR;
    logic [15:0]   GNT_CNT0, GNT_CNT1;
`endif

    data_arbiter #(.DW(DW), .BURST_MAX(BM)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_LAST(REQ0_LAST), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_LAST(REQ1_LAST), .REQ1_READY(REQ1_READY),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_SRC(OUT_SRC), .OUT_LAST(OUT_LAST),
        .OUT_READY(OUT_READY)
`ifdef ARB_CNT_EN
        , .CNT_CLR(CNT_CLR), .GNT_CNT0(GNT_CNT0), .GNT_CNT1(GNT_CNT1)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending beats per source, everything ever sent, and
    // the delivery/acceptance history used by the scenario checks.
    logic [32:0] q0[$], q1[$], s0[$], s1[$];
    int          rcv0, rcv1;
    int          acc_cyc[$];
    int          out_src[$];
    int          gbeats, gsrc;
    bit          bubble;

    task automatic clear_model();
        q0.delete(); q1.delete(); s0.delete(); s1.delete();
        acc_cyc.delete(); out_src.delete();
        rcv0 = 0; rcv1 = 0; gbeats = 0; gsrc = 0; bubble = 0;
    endtask

    task automatic idle_inputs();
        REQ0_VALID = 0; REQ0_DATA = '0; REQ0_LAST = 0;
        REQ1_VALID = 0; REQ1_DATA = '0; REQ1_LAST = 0;
        OUT_READY  = 0;
`ifdef ARB_CNT_EN
        CNT_CLR    = 0;
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 0;
        tick();
        tick();
        RST_N = 1;
        clear_model();
    endtask

    task automatic push_beat(input int s, input logic [31:0] d, input logic l);
        if (s == 0) begin q0.push_back({l, d}); s0.push_back({l, d}); end
        else        begin q1.push_back({l, d}); s1.push_back({l, d}); end
    endtask

    // Cycle engine: drives both sources from their queues, consumes output,
    // and checks the protocol rules every cycle.
    task automatic run(input int max_cyc, input bit rnd, input logic [63:0] stall);
        logic [31:0] pd;
        logic        ps, pl, pstall, done, a0, a1, lst;
        pstall = 0; done = 0; pd = '0; ps = 0; pl = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            REQ0_VALID = (q0.size() > 0) && (!rnd || $urandom_range(3) != 0);
            REQ0_DATA  = (q0.size() > 0) ? q0[0][31:0] : DW'($urandom);
            REQ0_LAST  = (q0.size() > 0) ? q0[0][32] : 1'b0;
            REQ1_VALID = (q1.size() > 0) && (!rnd || $urandom_range(3) != 0);
            REQ1_DATA  = (q1.size() > 0) ? q1[0][31:0] : DW'($urandom);
            REQ1_LAST  = (q1.size() > 0) ? q1[0][32] : 1'b0;
            OUT_READY  = rnd ? ($urandom_range(9) < 7) : !(c < 64 && stall[c]);
            #1;
            n_chk++;
            if (REQ0_READY && REQ1_READY) begin
                n_fail++; $display("FAIL both_ready cyc=%0d: got 11 required at most one", c);
            end
            if (OUT_VALID && !OUT_READY) begin
                n_chk++;
                if (REQ0_READY || REQ1_READY) begin
                    n_fail++; $display("FAIL ready_in_backpressure cyc=%0d: got %b%b required 00", c, REQ1_READY, REQ0_READY);
                end
            end
            if (pstall) begin
                n_chk++;
                if ({OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST} !== {1'b1, pd, ps, pl}) begin
                    n_fail++; $display("FAIL held_beat cyc=%0d: got %b/%h/%b/%b required 1/%h/%b/%b",
                                       c, OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST, pd, ps, pl);
                end
            end
            if (bubble) begin
                n_chk++;
                if (REQ0_READY || REQ1_READY) begin
                    n_fail++; $display("FAIL idle_bubble cyc=%0d: got ready %b%b required 00", c, REQ1_READY, REQ0_READY);
                end
            end
            if (OUT_VALID && OUT_READY) begin
                n_chk++;
                out_src.push_back(int'(OUT_SRC));
                if (OUT_SRC == 1'b0) begin
                    if (rcv0 >= s0.size()) begin
                        n_fail++; $display("FAIL extra_beat src0: got %h required none", OUT_DATA);
                    end else if ({OUT_LAST, OUT_DATA} !== s0[rcv0]) begin
                        n_fail++; $display("FAIL data_src0 #%0d: got %h required %h", rcv0, {OUT_LAST, OUT_DATA}, s0[rcv0]);
                    end
                    rcv0++;
                end else begin
                    if (rcv1 >= s1.size()) begin
                        n_fail++; $display("FAIL extra_beat src1: got %h required none", OUT_DATA);
                    end else if ({OUT_LAST, OUT_DATA} !== s1[rcv1]) begin
                        n_fail++; $display("FAIL data_src1 #%0d: got %h required %h", rcv1, {OUT_LAST, OUT_DATA}, s1[rcv1]);
                    end
                    rcv1++;
                end
            end
            a0 = REQ0_VALID && REQ0_READY;
            a1 = REQ1_VALID && REQ1_READY;
            bubble = 0;
            if (a0 || a1) begin
                if (gbeats == 0) gsrc = int'(a1);
                else begin
                    n_chk++;
                    if (int'(a1) != gsrc) begin
                        n_fail++; $display("FAIL grant_switch cyc=%0d: got src %0d required %0d", c, int'(a1), gsrc);
                    end
                end
                gbeats++;
                if (a1) lst = q1.pop_front() >> 32;
                else    lst = q0.pop_front() >> 32;
                acc_cyc.push_back(c);
                if (lst || gbeats == BM) begin gbeats = 0; bubble = 1; end
            end
            pstall = OUT_VALID && !OUT_READY;
            pd = OUT_DATA; ps = OUT_SRC; pl = OUT_LAST;
            tick();
            done = (q0.size() == 0) && (q1.size() == 0) && (rcv0 == s0.size()) && (rcv1 == s1.size());
        end
        idle_inputs();
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL run_timeout: got %0d/%0d delivered required %0d/%0d", rcv0, rcv1, s0.size(), s1.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        RST_N = 0;
        #1;
        n_chk++;
        if ({OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST, REQ0_READY, REQ1_READY} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b/%h/%b/%b/%b/%b required all zero",
                               OUT_VALID, OUT_DATA, OUT_SRC, OUT_LAST, REQ0_READY, REQ1_READY);
        end
`ifdef ARB_CNT_EN
        n_chk++;
        if (GNT_CNT0 !== 16'd0 || GNT_CNT1 !== 16'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", GNT_CNT0, GNT_CNT1);
        end
`endif
        tick();
        RST_N = 1;
        clear_model();
    endtask

    // Cycle-by-cycle latency, ordering and post-grant bubble for source 0.
    task automatic test_latency();
        logic        vin [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [31:0] din [7] = '{32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB0, 32'h0};
        logic        lin [7] = '{0, 0, 0, 1, 1, 1, 0};
        logic        erd [7] = '{0, 1, 1, 1, 0, 1, 0};
        logic        eov [7] = '{0, 0, 1, 1, 1, 0, 1};
        logic [31:0] eod [7] = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'h0, 32'hB0};
        logic        eol [7] = '{0, 0, 0, 0, 1, 0, 1};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            REQ0_VALID = vin[c]; REQ0_DATA = din[c]; REQ0_LAST = lin[c];
            OUT_READY  = 1;
            #1;
            n_chk++;
            if (REQ0_READY !== erd[c] || REQ1_READY !== 1'b0 || OUT_VALID !== eov[c]) begin
                n_fail++; $display("FAIL latency_ctrl cyc=%0d: got rdy0=%b rdy1=%b ov=%b required %b 0 %b",
                                   c, REQ0_READY, REQ1_READY, OUT_VALID, erd[c], eov[c]);
            end
            if (eov[c]) begin
                n_chk++;
                if (OUT_DATA !== eod[c] || OUT_LAST !== eol[c] || OUT_SRC !== 1'b0) begin
                    n_fail++; $display("FAIL latency_data cyc=%0d: got %h/%b/%b required %h/%b/0",
                                       c, OUT_DATA, OUT_LAST, OUT_SRC, eod[c], eol[c]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_beat(0, 32'h100 + i, 1'b1);
            push_beat(1, 32'h200 + i, 1'b1);
        end
        run(200, 0, '0);
        n_chk++;
        if (out_src.size() != 8) begin
            n_fail++; $display("FAIL rr_count: got %0d required 8", out_src.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_chk++;
                if (out_src[i] != i % 2) begin
                    n_fail++; $display("FAIL rr_order #%0d: got src %0d required %0d", i, out_src[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        for (int i = 0; i < 10; i++) push_beat(1, 32'hC000 + i, 1'b0);
        run(200, 0, '0);
        n_chk++;
        if (acc_cyc.size() != 10) begin
            n_fail++; $display("FAIL burst_count: got %0d required 10", acc_cyc.size());
        end else begin
            for (int i = 1; i < 10; i++) begin
                n_chk++;
                if (acc_cyc[i] - acc_cyc[i-1] != ((i % BM == 0) ? 2 : 1)) begin
                    n_fail++; $display("FAIL burst_gap beat%0d: got %0d required %0d",
                                       i, acc_cyc[i] - acc_cyc[i-1], (i % BM == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_acc [4] = '{1, 2, 8, 9};
        do_reset();
        for (int i = 0; i < 4; i++) push_beat(0, 32'hD0 + i, i == 3);
        run(200, 0, 64'h0000_0000_0000_00F8);
        n_chk++;
        if (acc_cyc.size() != 4) begin
            n_fail++; $display("FAIL bp_count: got %0d required 4", acc_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (acc_cyc[i] != exp_acc[i]) begin
                    n_fail++; $display("FAIL bp_accept_cycle #%0d: got %0d required %0d", i, acc_cyc[i], exp_acc[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        push_beat(0, 32'hE0, 1'b1);
        run(50, 0, '0);
        REQ0_VALID = 1; REQ0_DATA = 32'h55; REQ0_LAST = 0; OUT_READY = 1;
        tick();
        tick();
        #1;
        n_chk++;
        if (!(OUT_VALID === 1'b1 && REQ0_READY === 1'b1)) begin
            n_fail++; $display("FAIL mid_precond: got ov=%b rdy0=%b required 1 1", OUT_VALID, REQ0_READY);
        end
        RST_N = 0;
        #1;
        n_chk++;
        if (OUT_VALID !== 1'b0 || REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0 || OUT_DATA !== '0) begin
            n_fail++; $display("FAIL mid_reset: got ov=%b rdy=%b%b od=%h required 0 00 0",
                               OUT_VALID, REQ1_READY, REQ0_READY, OUT_DATA);
        end
        idle_inputs();
        tick();
        RST_N = 1;
        clear_model();
        push_beat(0, 32'hF0, 1'b1);
        push_beat(1, 32'hF1, 1'b1);
        run(50, 0, '0);
        n_chk++;
        if (out_src.size() == 0 || out_src[0] != 0) begin
            n_fail++; $display("FAIL mid_tie_after_reset: got first src %0d required 0",
                               out_src.size() ? out_src[0] : -1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int p = 0; p < 12; p++) begin
            for (int s = 0; s < 2; s++) begin
                int len = $urandom_range(6, 1);
                for (int b = 0; b < len; b++) push_beat(s, $urandom, b == len - 1);
            end
        end
        run(3000, 1, '0);
    endtask

`ifdef ARB_CNT_EN
    task automatic test_counters();
        bit hit;
        do_reset();
        for (int i = 0; i < 5; i++) push_beat(0, 32'h300 + i, i == 4);
        for (int i = 0; i < 3; i++) push_beat(1, 32'h400 + i, i == 2);
        run(200, 0, '0);
        #1;
        n_chk++;
        if (GNT_CNT0 !== 16'd5 || GNT_CNT1 !== 16'd3) begin
            n_fail++; $display("FAIL cnt_values: got %0d/%0d required 5/3", GNT_CNT0, GNT_CNT1);
        end
        REQ0_VALID = 1; REQ0_DATA = 32'h77; REQ0_LAST = 1; OUT_READY = 1;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            #1;
            hit = REQ0_READY;
            CNT_CLR = hit;
            tick();
        end
        idle_inputs();
        #1;
        n_chk++;
        if (!hit || GNT_CNT0 !== 16'd0 || GNT_CNT1 !== 16'd0) begin
            n_fail++; $display("FAIL cnt_clear: got hit=%b %0d/%0d required 1 0/0", hit, GNT_CNT0, GNT_CNT1);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        RST_N = 1;
        @(negedge CLK);
        test_reset();
        test_latency();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
`ifdef ARB_CNT_EN
        test_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_arbiter.md
# data_arbiter

Two-requester arbiter that shares one registered DW-bit output datapath between source 0 and source 1. It replaces a static bit-selected mux with valid/ready handshakes, round-robin grant and bounded bursts. It sits between the two input capture registers and the downstream consumer, all in one clock domain.

## Interface
- DW, 32, data width of each requester and of the output
- BURST_MAX, 4, maximum beats accepted per grant (legal range 1..15)
- CLK  input  1  sole clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- REQ0_VALID  input  1  source 0 beat valid
- REQ0_DATA  input  DW  source 0 beat data
- REQ0_LAST  input  1  source 0 final beat of packet
- REQ0_READY  output  1  source 0 beat accepted this cycle when high with REQ0_VALID
- REQ1_VALID / REQ1_DATA / REQ1_LAST / REQ1_READY  same as source 0, for source 1
- OUT_VALID  output  1  output register holds a beat
- OUT_DATA  output  DW  registered beat data
- OUT_SRC  output  1  source index of the held beat
- OUT_LAST  output  1  LAST flag of the held beat
- OUT_READY  input  1  consumer accepts held beat
- GNT_CNT0, GNT_CNT1  output  16  beat counters (present only with ARB_CNT_EN)
- CNT_CLR  input  1  synchronous counter clear (present only with ARB_CNT_EN)

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state IDLE.
- IDLE: when only REQx_VALID is high, go to GNTx. When both are high, go to the source not in LAST_GNT. LAST_GNT resets to 1, so source 0 wins the first tie. When neither is high, stay in IDLE.
- GNTx: REQx_READY = (state==GNTx) && (!OUT_VALID || OUT_READY). The other READY is 0. READY is never high in IDLE.
- Accepted beat (REQx_VALID && REQx_READY) loads OUT_DATA, OUT_SRC=x, OUT_LAST and sets OUT_VALID. Beat counter BCNT increments.
- GNTx exits to IDLE on an accepted beat with REQx_LAST=1, or on the accepted beat where BCNT==BURST_MAX-1. On exit: LAST_GNT<=x, BCNT<=0.
- If REQx_VALID drops while in GNTx, the grant is held with no timeout. A burst is only ended by LAST or BURST_MAX.
- Output stage: OUT_VALID clears on OUT_READY unless a new beat loads in the same cycle. Load and drain in the same cycle give full throughput.
- Width rules: BCNT is 4 bits and never exceeds BURST_MAX-1. Data passes unmodified.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, OUT_LAST=0, REQ0_READY=0, REQ1_READY=0, GNT_CNT0=0, GNT_CNT1=0, state IDLE, BCNT=0, LAST_GNT=1.
- Request latency: REQx_VALID first seen in IDLE at cycle t. GNTx starts at t+1, READY is high at t+1 (output empty), OUT_VALID is high at t+2.
- Steady-state throughput inside a grant is 1 beat/cycle with OUT_READY held high.
- After each grant ends there is a mandatory one-cycle IDLE bubble before the next grant.
- Backpressure: with OUT_VALID=1 and OUT_READY=0, READY is 0 and the held beat and all state are frozen.
- Reset mid-burst: state returns to IDLE immediately (asynchronous). The held output beat is discarded and no partial-burst state survives.

## Configuration
- ARB_CNT_EN defined: GNT_CNT0/GNT_CNT1 increment on each accepted beat of their source. They saturate at 16'hFFFF. CNT_CLR clears both and takes priority over an increment in the same cycle.
- ARB_CNT_EN undefined: counters, GNT_CNT0/1 and CNT_CLR ports are absent. Arbitration behaviour is identical.

## Structure
- Package arb_pkg holds: FSM state typedef (IDLE, GNT0, GNT1), default DW=32, BCNT width constant 4, counter width 16.
- One sub-module, arb_out_reg, holds the output register stage (load/drain/valid logic, DW-parameterised). FSM and grant logic stay in data_arbiter.

## Test plan
- Reset, then source 0 sends 3 beats 0xA0,0xA1,0xA2 (LAST on the third), OUT_READY=1 -> OUT_VALID first high 2 cycles after VALID. Beats appear in order with OUT_SRC=0 and OUT_LAST on 0xA2, then one IDLE cycle.
- Both sources present from reset, single-beat packets, 4 rounds -> grant order 0,1,0,1. No two consecutive grants go to the same source.
- Source 1 streams 10 beats with no LAST, BURST_MAX=4, source 0 idle -> grants end after beats 4 and 8 with an IDLE bubble after each. All 10 beats are delivered in order.
- OUT_READY low for 5 cycles mid-burst -> REQx_READY stays 0, OUT_DATA is stable, no beat is lost or duplicated after release.
- RST_N asserted while in GNT0 with OUT_VALID=1 -> OUT_VALID=0 and both READY=0 immediately. After release, a tie is granted to source 0.
- With ARB_CNT_EN: 5 beats from source 0 and 3 from source 1 -> GNT_CNT0=5, GNT_CNT1=3. CNT_CLR pulsed together with an accepted beat -> both counters read 0.
